// File: rtl/event_toggle_tx_if.sv
// Handshake bundle between an event source and the toggle transmitter:
// requests flow in, the toggle line and queue status flow out.
interface event_toggle_tx_if #(
  parameter int CNT_W = 4
) ();
  logic             i_Event;
  logic             i_Clear;
  logic             o_Toggle;
  logic [CNT_W-1:0] o_Pending;
  logic             o_Full;
  logic             o_Overflow;
  logic             o_Idle;

  modport master (
    output i_Event, i_Clear,
    input  o_Toggle, o_Pending, o_Full, o_Overflow, o_Idle
  );

  modport slave (
    input  i_Event, i_Clear,
    output o_Toggle, o_Pending, o_Full, o_Overflow, o_Idle
  );
endinterface

// File: rtl/event_toggle_tx.sv
// Toggle-line event transmitter: each launched event flips o_Toggle, with
// launches spaced HOLD_CYCLES apart and excess events queued in a saturating counter.
module event_toggle_tx #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  event_toggle_tx_if.slave   bus
);

  localparam logic [CNT_W:0] PEND_MAX  = {1'b0, {CNT_W{1'b1}}};
  localparam logic [7:0]     HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             toggle_q, toggle_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic             full_q, full_d;
  logic             idle_q, idle_d;
  logic             launch;
  logic [CNT_W:0]   pend_sum;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    hold_d   = hold_q;
    toggle_d = toggle_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    launch   = 1'b0;
    pend_sum = '0;

    if (state_q == S_IDLE) begin
      launch = bus.i_Event && !bus.i_Clear;
    end else begin
      launch = (hold_q == 8'd0) && ((pend_q != '0) || bus.i_Event) && !bus.i_Clear;
    end

    if (launch) begin
      toggle_d = ~toggle_q;
      hold_d   = HOLD_LOAD;
      state_d  = S_HOLD;
    end else if (state_q == S_HOLD) begin
      if (hold_q != 8'd0) hold_d  = hold_q - 8'd1;
      else                state_d = S_IDLE;
    end

    // A launch always retires one event: a queued one if any, else this cycle's request.
    pend_sum = {1'b0, pend_q} + (CNT_W+1)'(bus.i_Event) - (CNT_W+1)'(launch);

    if (bus.i_Clear) begin
      pend_d = '0;
      ovf_d  = 1'b0;
    end else if (pend_sum > PEND_MAX) begin
      pend_d = PEND_MAX[CNT_W-1:0];
      ovf_d  = 1'b1;
    end else begin
      pend_d = pend_sum[CNT_W-1:0];
    end

    full_d = (pend_d == PEND_MAX[CNT_W-1:0]);
    idle_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      hold_q   <= 8'd0;
      toggle_q <= 1'b0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      full_q   <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q  <= state_d;
      hold_q   <= hold_d;
      toggle_q <= toggle_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      full_q   <= full_d;
      idle_q   <= idle_d;
    end
  end

  assign bus.o_Toggle   = toggle_q;
  assign bus.o_Pending  = pend_q;
  assign bus.o_Full     = full_q;
  assign bus.o_Overflow = ovf_q;
  assign bus.o_Idle     = idle_q;

endmodule
